// File: rtl/core_initiator_if.sv
// Command/response and core-bus signals of core_initiator, grouped for port connection.
// The master modport is the initiator's view; slave is the command issuer plus the core.
interface core_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_address;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        bus_cs;
  logic        bus_we;
  logic [7:0]  bus_address;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ready;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_address, cmd_wdata, bus_read_data, bus_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           bus_cs, bus_we, bus_address, bus_write_data, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_address, cmd_wdata, bus_read_data, bus_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           bus_cs, bus_we, bus_address, bus_write_data, busy
  );
endinterface

// File: rtl/core_initiator.sv
// Single-outstanding register-bus initiator: one command -> one chip-select access
// (with wait-state timeout) -> one-cycle response strobe.
module core_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             reset,
  core_initiator_if.master ifc
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  // bus_ready wins over the timeout when both hit on the same edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ifc.cmd_valid) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (ifc.bus_ready) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifc.cmd_ready = (state_q == IDLE);
    ifc.busy      = (state_q != IDLE);

    cs_d     = (state_d == ACCESS);
    rvalid_d = (state_q == ACCESS) && (state_d == RESP);
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = cs_d ? we_q : 1'b0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;

    if (state_q == IDLE && ifc.cmd_valid) begin
      addr_d  = ifc.cmd_address;
      wdata_d = ifc.cmd_wdata;
      we_d    = ifc.cmd_we;
    end

    if (rvalid_d) begin
      rerr_d  = !ifc.bus_ready;
      rdata_d = (ifc.bus_ready && !we_q) ? ifc.bus_read_data : '0;
    end
  end

  assign ifc.bus_cs         = cs_q;
  assign ifc.bus_we         = we_q;
  assign ifc.bus_address    = addr_q;
  assign ifc.bus_write_data = wdata_q;
  assign ifc.rsp_valid      = rvalid_q;
  assign ifc.rsp_rdata      = rdata_q;
  assign ifc.rsp_error      = rerr_q;

endmodule

// File: tb/tb_core_initiator.sv
// Self-checking bench for core_initiator: transaction-schedule model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_core_initiator;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_initiator_if ifc ();

  core_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc)
  );

  // Core model: asserts ready once bus_cs has been high for core_lat earlier cycles.
  int          core_lat = 0;
  int          core_cnt = 0;
  logic [31:0] core_rd  = '0;
  always @(posedge clk) begin
    if (reset || !ifc.bus_cs) core_cnt <= 0;
    else                      core_cnt <= core_cnt + 1;
  end
  assign ifc.bus_ready     = ifc.bus_cs && (core_cnt >= core_lat);
  assign ifc.bus_read_data = ifc.bus_ready ? core_rd : ~core_rd;

  int checks = 0;
  int errors = 0;

  // Schedule model: an access accepted at edge e lasts n cs-cycles, response in cycle e+n.
  int          k = 0;
  bit          active = 0;
  int          e, n;
  bit          m_err_cur, m_we;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_wdata = '0, m_rd_cur = '0, m_rdata = '0;
  bit          m_err = 0;

  int cs_run = 0, last_run = 0, rv_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic check_cycle();
    bit exp_cs, exp_rv;
    exp_cs = active && (k < e + n);
    exp_rv = active && (k == e + n);
    if (exp_rv) begin
      m_err   = m_err_cur;
      m_rdata = (m_err_cur || m_we) ? 32'h0 : m_rd_cur;
    end
    chk("cmd_ready", 32'(ifc.cmd_ready), 32'(!active));
    chk("busy", 32'(ifc.busy), 32'(active));
    chk("bus_cs", 32'(ifc.bus_cs), 32'(exp_cs));
    chk("bus_we", 32'(ifc.bus_we), 32'(exp_cs && m_we));
    chk("bus_address", 32'(ifc.bus_address), 32'(m_addr));
    chk("bus_write_data", ifc.bus_write_data, m_wdata);
    chk("rsp_valid", 32'(ifc.rsp_valid), 32'(exp_rv));
    chk("rsp_rdata", ifc.rsp_rdata, m_rdata);
    chk("rsp_error", 32'(ifc.rsp_error), 32'(m_err));
    if (ifc.bus_cs === 1'b1) cs_run++;
    else if (cs_run > 0) begin last_run = cs_run; cs_run = 0; end
    if (ifc.rsp_valid === 1'b1) rv_count++;
  endtask

  // Drive inputs for the next edge, advance the model across it, then check.
  task automatic cycle(input bit rst, input bit v, input bit we, input logic [7:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd);
    bit accept;
    reset = rst; ifc.cmd_valid = v; ifc.cmd_we = we; ifc.cmd_address = a; ifc.cmd_wdata = wd;
    if (rst) begin
      active = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
    end else begin
      accept = v && !active;
      if (active && k == e + n) active = 0;
      if (accept) begin
        active = 1; e = k + 1;
        n = (lat >= TO) ? TO : lat + 1;
        m_err_cur = (lat >= TO);
        m_we = we; m_addr = a; m_wdata = wd; m_rd_cur = rd;
        core_lat = lat; core_rd = rd;
      end
    end
    @(posedge clk);
    k++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 0, 32'h0);
  endtask

  task automatic run_cmd(input bit we, input logic [7:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] rd);
    int guard;
    cycle(1'b0, 1'b1, we, a, wd, lat, rd);
    guard = 0;
    while (active && guard < 300) begin idle(); guard++; end
    chk("run_cmd_bound", 32'(active), 32'(0));
  endtask

  initial begin
    int rv0;
    reset = 1'b1; ifc.cmd_valid = 1'b0; ifc.cmd_we = 1'b0;
    ifc.cmd_address = '0; ifc.cmd_wdata = '0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 8'h55, 32'hdead_beef, 0, 32'h0);
    chk("reset_cs", 32'(ifc.bus_cs), 32'h0);
    chk("reset_addr", 32'(ifc.bus_address), 32'h0);
    chk("reset_cmd_ready", 32'(ifc.cmd_ready), 32'h1);
    idle();

    // Single write, immediate ready
    run_cmd(1'b1, 8'h0a, 32'h0100_0000, 0, 32'hffff_ffff);
    chk("wr_cs_len", 32'(last_run), 32'd1);
    chk("wr_rdata", ifc.rsp_rdata, 32'h0);
    chk("wr_err", 32'(ifc.rsp_error), 32'h0);
    chk("wr_addr_hold", 32'(ifc.bus_address), 32'h0a);

    // Read, immediate ready
    run_cmd(1'b0, 8'h0b, 32'h0, 0, 32'h0123_4567);
    chk("rd_rdata", ifc.rsp_rdata, 32'h0123_4567);
    chk("rd_err", 32'(ifc.rsp_error), 32'h0);

    // Five wait states
    run_cmd(1'b0, 8'h21, 32'h0, 5, 32'haaaa_5555);
    chk("wait5_cs_len", 32'(last_run), 32'd6);
    chk("wait5_err", 32'(ifc.rsp_error), 32'h0);

    // Ready on the last allowed cycle
    run_cmd(1'b0, 8'h22, 32'h0, TO - 1, 32'h1357_9bdf);
    chk("edge_cs_len", 32'(last_run), 32'd16);
    chk("edge_err", 32'(ifc.rsp_error), 32'h0);
    chk("edge_rdata", ifc.rsp_rdata, 32'h1357_9bdf);

    // Core never ready
    run_cmd(1'b0, 8'h23, 32'h0, 1000, 32'hcafe_f00d);
    chk("to_cs_len", 32'(last_run), 32'd16);
    chk("to_err", 32'(ifc.rsp_error), 32'h1);
    chk("to_rdata", ifc.rsp_rdata, 32'h0);
    run_cmd(1'b1, 8'h24, 32'h0000_0042, 0, 32'h0);
    chk("after_to_err", 32'(ifc.rsp_error), 32'h0);

    // Back-to-back with cmd_valid held high: 4 commands in 12 cycles
    rv0 = rv_count;
    for (int i = 0; i < 12; i++)
      cycle(1'b0, 1'b1, i[0], 8'(8'h30 + i), 32'(i), 0, 32'(32'h100 + i));
    idle(); idle();
    chk("b2b_responses", 32'(rv_count - rv0), 32'd4);

    // Reset on the third wait cycle of a read
    cycle(1'b0, 1'b1, 1'b0, 8'h0b, 32'h0, 20, 32'h7777_7777);
    idle(); idle();
    rv0 = rv_count;
    cycle(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 0, 32'h0);
    chk("rst_mid_cs", 32'(ifc.bus_cs), 32'h0);
    idle();
    chk("rst_mid_ready", 32'(ifc.cmd_ready), 32'h1);
    for (int i = 0; i < 20; i++) idle();
    chk("rst_mid_no_rsp", 32'(rv_count - rv0), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_v, r_we;
      int          r_lat;
      r_rst = ($urandom_range(0, 99) == 0);
      r_v   = ($urandom_range(0, 1) == 1);
      r_we  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0, 1:    r_lat = $urandom_range(0, 2);
        2:       r_lat = $urandom_range(3, 10);
        default: r_lat = $urandom_range(TO - 2, TO + 3);
      endcase
      cycle(r_rst, r_v, r_we, 8'($urandom), $urandom, r_lat, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
